maze_wall_scheduler: RTL
========================

Name: maze_wall_scheduler

Overview:
- Time-shares the single combinational maze wall-lookup port between two requesters (player A and player B in a two-player race).
- The lookup port takes x, x_alt, y, y_alt and returns horizontal/vertical wall bits.
- Each request fetches the four walls of one cell in two lookup phases: base and +1.
- Results are returned per requester with a one-cycle valid pulse.

Parameters:
- None. Coordinates are fixed at 4 bits (16x16 maze).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- req_a  in  1  requester A wants a wall fetch (level)
- pos_a  in  8  cell to fetch for A, {x[3:0], y[3:0]}
- walls_a  out  4  A's walls {left, bottom, right, top}; 1 = wall
- valid_a  out  1  one-cycle pulse: walls_a updated this cycle
- req_b, pos_b, walls_b, valid_b  same as A, for requester B
- lk_x, lk_x_alt, lk_y, lk_y_alt  out  4 each  lookup address to maze wall data
- lk_horizontal  in  1  wall above row lk_y_alt at column lk_x
- lk_vertical  in  1  wall left of column lk_x_alt at row lk_y
- busy  out  1  high in any state other than IDLE

Behaviour:
- Clocking and reset: one clock clk; synchronous active-high rst. All state updates on the rising edge of clk.
- Reset values:
  - walls_a = walls_b = 4'hF (all closed)
  - valid_a = valid_b = 0
  - lk_* = 0, busy = 0
  - state = IDLE
  - last_grant = B, so A wins the first tie.
- FSM states: IDLE, PH0, PH1, RESP.
- IDLE:
  - lk_* driven 0.
  - If any req is high, grant one requester, latch its pos into cur_x/cur_y, record the owner and go to PH0. Otherwise stay in IDLE.
- Arbitration:
  - Only one requester high: it wins.
  - Both high: the one not equal to last_grant wins.
  - last_grant updates on each grant.
- PH0:
  - Drive lk_x = lk_x_alt = cur_x and lk_y = lk_y_alt = cur_y.
  - Capture top <= lk_horizontal and left <= lk_vertical into a staging register. Go to PH1.
- PH1:
  - Drive lk_x = cur_x, lk_x_alt = cur_x+1, lk_y = cur_y, lk_y_alt = cur_y+1. Both +1 are 4-bit, wrapping 15 -> 0.
  - Capture bottom <= lk_horizontal and right <= lk_vertical. Go to RESP.
- RESP:
  - The owner's walls_* is loaded with the staging value.
  - The owner's valid_* is high for exactly this cycle.
  - lk_* driven 0. Next state is IDLE.
- Latency:
  - req sampled high in IDLE at cycle t -> PH0 at t+1, PH1 at t+2, valid at t+3.
  - Maximum throughput is one fetch per 4 cycles.
  - Worst-case wait under contention is 8 cycles.
- Position handling: pos is sampled only at grant. Changes during PH0/PH1 are ignored.
- Request withdrawal: if req drops after grant, the fetch still completes and valid still pulses.
- Output hold: walls_* keep their last value between valid pulses. The non-owner's walls and valid are untouched.
- Reset during PH0/PH1/RESP: abort immediately. No valid pulse; walls return to 4'hF.
- valid_a and valid_b are never high in the same cycle.

Optional Feature:
- Macro: MAZE_SCHED_CACHE_EN.
- Defined:
  - Each requester keeps a tag (pos of its last completed fetch) plus a tag_ok bit. tag_ok is cleared by reset and set at RESP.
  - In IDLE, if the granted requester's pos equals its tag and tag_ok = 1, the FSM goes directly to RESP and skips PH0/PH1. The owner's walls are rewritten unchanged, and valid pulses at t+1.
  - A cache hit still counts as a grant for last_grant.
  - lk_* stay 0 for the whole hit; no lookup occurs.
- Undefined: no tags; every grant performs PH0/PH1 as above.

Test Plan:
- Reset: rst high 2 cycles -> walls_a = walls_b = 4'hF, valid_a = valid_b = 0, busy = 0, lk_* = 0.
- Single fetch, A only:
  - Stimulus: req_a = 1, pos_a = 8'h34 at t. Maze model gives PH0 (H=1, V=0) and PH1 (H=0, V=1).
  - Required: lk = (3,3,4,4) at t+1 and (3,4,4,5) at t+2; valid_a at t+3 with walls_a = 4'b0011; walls_b unchanged.
- Contention: req_a = req_b = 1 held -> grants in order A, B, A, B; valid_a at t+3, valid_b at t+7, valid_a at t+11; never both valid in one cycle.
- Wrap-around: pos_b = 8'hFF -> in PH1 lk_x_alt = 0 and lk_y_alt = 0.
- Abort and withdrawal:
  - rst asserted during PH1 -> no valid pulse, walls return to 4'hF.
  - req_a dropped in PH0 -> valid_a still at t+3.
- Cache (only with MAZE_SCHED_CACHE_EN): repeat fetch of pos_a = 8'h34 after a completed one -> valid_a at t+1 with the same walls, busy only 1 cycle, lk_* stay 0.

Source files
------------

// File: rtl/maze_wall_scheduler.sv
// maze_wall_scheduler: shares one combinational maze wall-lookup port between
// two requesters (A and B). Each fetch reads the four walls of a cell in two
// lookup phases (base cell, then the +1 neighbours) and returns them with a
// one-cycle valid pulse to the requester that owns the fetch.
// Optional feature: define MAZE_SCHED_CACHE_EN to keep a one-entry tag per
// requester so that a repeat fetch of the same cell skips the lookup phases.
module maze_wall_scheduler (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_a,
    input  logic [7:0] pos_a,
    output logic [3:0] walls_a,
    output logic       valid_a,
    input  logic       req_b,
    input  logic [7:0] pos_b,
    output logic [3:0] walls_b,
    output logic       valid_b,
    output logic [3:0] lk_x,
    output logic [3:0] lk_x_alt,
    output logic [3:0] lk_y,
    output logic [3:0] lk_y_alt,
    input  logic       lk_horizontal,
    input  logic       lk_vertical,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, PH0, PH1, RESP} state_t;

    state_t     state;
    state_t     next_state;

    // owner / last_grant encoding: 0 = requester A, 1 = requester B
    logic       owner;
    logic       last_grant;
    logic [3:0] cur_x;
    logic [3:0] cur_y;
    logic [3:0] stage;
    logic [3:0] walls_a_q;
    logic [3:0] walls_b_q;
    logic       grant;
    logic       grant_b;
    logic       hit;
    logic       resp_live;

`ifdef MAZE_SCHED_CACHE_EN
    logic [7:0] tag_a;
    logic [7:0] tag_b;
    logic       tag_ok_a;
    logic       tag_ok_b;
`endif

    // Arbitration: a lone requester wins; on a tie the one not granted last wins
    always_comb begin
        grant   = req_a | req_b;
        grant_b = req_b & (~req_a | ~last_grant);
`ifdef MAZE_SCHED_CACHE_EN
        if (grant_b) begin
            hit = tag_ok_b & (tag_b == pos_b);
        end else begin
            hit = tag_ok_a & (tag_a == pos_a);
        end
`else
        hit = 1'b0;
`endif
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: fixed walk through the two lookup phases, or a jump
    // straight to RESP when the cache already holds the requested cell
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (grant) begin
                    next_state = hit ? RESP : PH0;
                end
            end
            PH0:     next_state = PH1;
            PH1:     next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath: latch the granted position, stage the wall bits from each
    // lookup phase, and commit the staged walls to the owner in RESP
    always_ff @(posedge clk) begin
        if (rst) begin
            owner      <= 1'b0;
            last_grant <= 1'b1;
            cur_x      <= 4'd0;
            cur_y      <= 4'd0;
            stage      <= 4'hF;
            walls_a_q  <= 4'hF;
            walls_b_q  <= 4'hF;
`ifdef MAZE_SCHED_CACHE_EN
            tag_a      <= 8'd0;
            tag_b      <= 8'd0;
            tag_ok_a   <= 1'b0;
            tag_ok_b   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        owner      <= grant_b;
                        last_grant <= grant_b;
                        cur_x      <= grant_b ? pos_b[7:4] : pos_a[7:4];
                        cur_y      <= grant_b ? pos_b[3:0] : pos_a[3:0];
                        if (hit) begin
                            stage <= grant_b ? walls_b_q : walls_a_q;
                        end
                    end
                end
                PH0: begin
                    stage[0] <= lk_horizontal;
                    stage[3] <= lk_vertical;
                end
                PH1: begin
                    stage[2] <= lk_horizontal;
                    stage[1] <= lk_vertical;
                end
                RESP: begin
                    if (owner) begin
                        walls_b_q <= stage;
`ifdef MAZE_SCHED_CACHE_EN
                        tag_b    <= {cur_x, cur_y};
                        tag_ok_b <= 1'b1;
`endif
                    end else begin
                        walls_a_q <= stage;
`ifdef MAZE_SCHED_CACHE_EN
                        tag_a    <= {cur_x, cur_y};
                        tag_ok_a <= 1'b1;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs: lookup address per phase, valid pulse and live walls in RESP
    // (a reset arriving in RESP suppresses the pulse)
    always_comb begin
        lk_x      = 4'd0;
        lk_x_alt  = 4'd0;
        lk_y      = 4'd0;
        lk_y_alt  = 4'd0;
        case (state)
            PH0: begin
                lk_x     = cur_x;
                lk_x_alt = cur_x;
                lk_y     = cur_y;
                lk_y_alt = cur_y;
            end
            PH1: begin
                lk_x     = cur_x;
                lk_x_alt = cur_x + 4'd1;
                lk_y     = cur_y;
                lk_y_alt = cur_y + 4'd1;
            end
            default: ;
        endcase
        busy      = (state != IDLE);
        resp_live = (state == RESP) & ~rst;
        valid_a   = resp_live & ~owner;
        valid_b   = resp_live & owner;
        walls_a   = valid_a ? stage : walls_a_q;
        walls_b   = valid_b ? stage : walls_b_q;
    end

endmodule
